// File: rtl/delta_decoder.sv
// delta_decoder: rebuilds an absolute value stream from a base value plus add/sub delta magnitudes
module delta_decoder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] base_in,
  input  logic             delta_valid,
  input  logic [WIDTH-1:0] delta_in,
  input  logic             delta_sub,
  output logic             delta_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic             accept;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state, handshake and the carry/borrow-extended sum
  always_comb begin
    state_nx    = load ? RUN : state;
    delta_ready = (state == RUN) && !load && (!out_valid || out_ready);
    accept      = delta_valid && delta_ready;
    sum         = delta_sub ? {1'b0, acc} - {1'b0, delta_in} : {1'b0, acc} + {1'b0, delta_in};
  end
  // accumulator, output register, sticky overflow and saturating sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      count     <= '0;
    end else if (load) begin
      acc       <= base_in;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      acc       <= sum[WIDTH-1:0];
      out_data  <= sum[WIDTH-1:0];
      out_valid <= 1'b1;
      overflow  <= overflow | sum[WIDTH];
      count     <= &count ? count : count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_delta_decoder.sv
// tb_delta_decoder: scoreboard bench for delta_decoder
module tb_delta_decoder;
  logic        clk = 1'b0;
  logic        rst, load, delta_valid, delta_sub, out_ready;
  logic [31:0] base_in, delta_in;
  logic        delta_ready, out_valid, overflow;
  logic [31:0] out_data;
  logic [15:0] count;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        done;

  delta_decoder dut (
    .clk(clk), .rst(rst), .load(load), .base_in(base_in),
    .delta_valid(delta_valid), .delta_in(delta_in), .delta_sub(delta_sub),
    .delta_ready(delta_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // every consumed output is compared with the oldest expected value
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_out", out_data, 32'hDEADBEEF);
      else check("out_data", out_data, q.pop_front());
    end
  end

  task automatic send(input logic sub, input logic [31:0] d);
    logic        ok;
    logic [32:0] s;
    ok = 1'b0;
    delta_valid = 1'b1;
    delta_sub = sub;
    delta_in = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = delta_ready;
      if (ok) begin
        s = sub ? {1'b0, m_acc} - {1'b0, d} : {1'b0, m_acc} + {1'b0, d};
        m_acc = s[31:0];
        m_ovf = m_ovf | s[32];
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        q.push_back(s[31:0]);
      end
      @(posedge clk);
      #1;
    end
    delta_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] b);
    load = 1'b1;
    base_in = b;
    @(posedge clk);
    #1;
    load = 1'b0;
    q.delete();
    m_acc = b;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain", q.size(), 32'd0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    check({tag, "_cnt"}, {16'd0, count}, {16'd0, m_cnt});
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; delta_valid = 1'b0; delta_sub = 1'b0;
    out_ready = 1'b0; base_in = '0; delta_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_cnt", {16'd0, count}, 32'd0);
    check("rst_ready", {31'd0, delta_ready}, 32'd0);
    delta_valid = 1'b1; delta_in = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, delta_ready}, 32'd0);
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    delta_valid = 1'b0;
    check("idle_cnt", {16'd0, count}, 32'd0);

    out_ready = 1'b1;
    do_load(32'd100);
    send(1'b0, 32'd12);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", out_data, 32'd112);
    send(1'b1, 32'd34);
    send(1'b0, 32'd56);
    drain();
    check("seq_last", out_data, 32'd134);
    check_status("seq");
    check("seq_cnt3", {16'd0, count}, 32'd3);

    do_load(32'hFFFF_FFF0);
    send(1'b0, 32'h20);
    drain();
    check("wrap_ovf", {31'd0, overflow}, 32'd1);
    send(1'b0, 32'h1);
    drain();
    check("wrap_data", out_data, 32'h11);
    check_status("wrap");
    do_load(32'd5);
    check_status("reload");
    check("load_keeps_data", out_data, 32'h11);
    check("load_clears_valid", {31'd0, out_valid}, 32'd0);

    do_load(32'd10);
    send(1'b1, 32'd11);
    drain();
    check("borrow_data", out_data, 32'hFFFF_FFFF);
    check("borrow_ovf", {31'd0, overflow}, 32'd1);

    do_load(32'd0);
    out_ready = 1'b0;
    send(1'b0, 32'd7);
    delta_valid = 1'b1; delta_in = 32'd3; delta_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", {31'd0, delta_ready}, 32'd0);
      check("bp_hold", out_data, 32'd7);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1'b0, 32'd3);
    drain();
    check("bp_final", out_data, 32'd10);
    check_status("bp");

    out_ready = 1'b0;
    send(1'b0, 32'd5);
    load = 1'b1; base_in = 32'd1000;
    delta_valid = 1'b1; delta_in = 32'd9; delta_sub = 1'b0;
    @(negedge clk);
    check("ld_pri_ready", {31'd0, delta_ready}, 32'd0);
    @(posedge clk);
    #1;
    load = 1'b0;
    q.delete();
    m_acc = 32'd1000; m_ovf = 1'b0; m_cnt = '0;
    check("ld_pri_valid", {31'd0, out_valid}, 32'd0);
    check("ld_pri_data", out_data, 32'd15);
    check_status("ld_pri");
    out_ready = 1'b1;
    send(1'b0, 32'd9);
    drain();
    check("ld_pri_next", out_data, 32'd1009);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), $urandom);
        done = 1'b1;
      end
      begin
        for (int i = 0; i < 2000 && !done; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check_status("rand");

    out_ready = 1'b0;
    send(1'b0, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_cnt", {16'd0, count}, 32'd0);
    delta_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", {31'd0, delta_ready}, 32'd0);
    delta_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/delta_decoder.md
Name: delta_decoder

Overview:
- Sequential inverse of the datapath difference unit: rebuilds an absolute 32-bit value stream from a base value plus a stream of unsigned magnitudes, each tagged add or subtract.
- Used after the difference unit, or anywhere the datapath sends deltas instead of full words.
- Valid/ready handshake on both sides.
- One-cycle latency.
- Sticky overflow flag and a sample counter for debug.

Parameters:
- WIDTH, 32, data width of base, delta, accumulator and output.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  load base_in into the accumulator
- base_in  input  WIDTH  base (initial) value
- delta_valid  input  1  delta_in/delta_sub are valid
- delta_in  input  WIDTH  unsigned delta magnitude
- delta_sub  input  1  0: acc + delta; 1: acc - delta
- delta_ready  output  1  decoder can accept a delta this cycle
- out_valid  output  1  out_data holds a reconstructed value
- out_data  output  WIDTH  reconstructed value
- out_ready  input  1  downstream consumes out_data
- overflow  output  1  sticky: unsigned carry (add) or borrow (sub) seen since last load/reset
- count  output  CNT_W  deltas accepted since last load, saturating

Behaviour:
- Reset: state=IDLE, acc=0, out_valid=0, out_data=0, overflow=0, count=0, delta_ready=0. Reset mid-transfer discards any pending output.
- State IDLE: no base loaded.
  - delta_ready=0.
  - load=1 -> acc<=base_in, go to RUN.
- State RUN:
  - delta_ready = !load && (!out_valid || out_ready).
  - load=1 -> acc<=base_in, out_valid<=0 (pending output dropped), overflow<=0, count<=0. Stay in RUN.
  - load has priority: a delta presented in the same cycle is not accepted, because delta_ready is 0.
- Accept: when delta_valid && delta_ready, sum = acc + delta_in (delta_sub=0) or acc - delta_in (delta_sub=1), computed WIDTH+1 bits wide.
  - acc<=sum[WIDTH-1:0] and out_data<=sum[WIDTH-1:0] (wraps mod 2^WIDTH).
  - out_valid<=1.
  - overflow<=overflow | sum[WIDTH] (carry for add, borrow for sub).
  - count<=count+1, saturating at all-ones.
- Latency: value from a delta accepted at edge N appears on out_data after edge N, so it is visible in cycle N+1.
- Output hold: while out_valid=1 && out_ready=0, out_data and out_valid hold. delta_ready=0, so there is no loss.
- Output drain: out_valid && out_ready && no accept -> out_valid<=0.
- Simultaneous pop and accept: same cycle -> out_valid stays 1 and out_data takes the new value. Full throughput is one delta per cycle.
- delta_in=0: legal. It produces an output equal to acc and increments count.
- out_data does not change on load; only out_valid clears.
- Signals from upstream are sampled only on accept; changes while delta_ready=0 have no effect.

Test Plan:
- Reset then delta_valid=1 with no load -> delta_ready=0 and out_valid=0 for 5 cycles; count=0.
- load base 100, then deltas (+12 add), (34 sub), (56 add) with out_ready=1 -> outputs 112, 78, 134 in consecutive cycles. count=3, overflow=0.
- base 0xFFFFFFF0, add 0x20 -> out 0x00000010, overflow=1. Then add 1 -> out 0x00000011, overflow still 1. load 5 -> overflow=0, count=0.
- base 10, sub 11 -> out 0xFFFFFFFF, overflow=1 (borrow).
- Backpressure: base 0, hold out_ready=0 after first add 7 -> out_data=7 held, delta_ready=0. Second delta (add 3) is stalled. Raise out_ready -> next cycle out_data=10, no delta lost.
- load and delta_valid asserted in the same cycle while an output is pending -> the delta is not accepted and out_valid drops. acc=base_in; the next accepted delta is applied to base_in. Separately, assert rst mid-stream -> all outputs are 0 and state is IDLE next cycle.
